// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and default frame parameters,
// common to the transmitter and receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

endpackage

// File: rtl/uart_tx_if.sv
// Producer-facing port bundle of the UART transmitter, plus its FSM state for observation.
// Handshake: a byte is taken on tx_data in any clk cycle where tx_start && tx_ready; tx_start while tx_ready=0 is dropped.
interface uart_tx_if #(
   parameter int DATA_BITS = uart_pkg::DATA_BITS_DEF
);
   logic                    b_tick;
   logic                    tx_start;
   logic [DATA_BITS-1:0]    tx_data;
   logic                    tx_ready;
   logic                    tx_busy;
   logic                    tx_done;
   logic                    tx;
   uart_pkg::uart_state_t   state;

   modport master (
      output b_tick, tx_start, tx_data,
      input  tx_ready, tx_busy, tx_done, tx, state
   );

   modport slave (
      input  b_tick, tx_start, tx_data,
      output tx_ready, tx_busy, tx_done, tx, state
   );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, paced by a 16x oversampling tick, with a
// one-entry holding register so consecutive frames leave with no idle gap.
module uart_tx
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int DATA_BITS  = DATA_BITS_DEF
) (
   input logic       clk,
   input logic       rst,
   uart_tx_if.slave  bus
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

   uart_state_t          state_q, state_d;
   logic [TW-1:0]        tick_q, tick_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] hold_q, hold_d;
   logic                 hold_valid_q, hold_valid_d;
   logic                 tx_q, tx_d;
   logic                 done_q, done_d;
   logic                 accept;
   logic                 tick_end;

   assign accept   = bus.tx_start && !hold_valid_q;
   assign tick_end = bus.b_tick && (tick_q == TICK_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         tick_q       <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         tx_q         <= 1'b1;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         tick_q       <= tick_d;
         bit_q        <= bit_d;
         shift_q      <= shift_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         tx_q         <= tx_d;
         done_q       <= done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      tick_d       = tick_q;
      bit_d        = bit_q;
      shift_d      = shift_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      done_d       = 1'b0;

      // While a frame is on the line, an accepted write parks in the holding register.
      if (accept && state_q != IDLE) begin
         hold_d       = bus.tx_data;
         hold_valid_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            tick_d = '0;
            if (hold_valid_q) begin
               shift_d      = hold_q;
               hold_valid_d = 1'b0;
               state_d      = START;
            end else if (accept) begin
               shift_d = bus.tx_data;
               state_d = START;
            end
         end
         START: begin
            if (tick_end) begin
               tick_d  = '0;
               bit_d   = '0;
               state_d = DATA;
            end else if (bus.b_tick) begin
               tick_d = tick_q + 1'b1;
            end
         end
         DATA: begin
            if (tick_end) begin
               tick_d = '0;
               if (bit_q == BIT_LAST) begin
                  state_d = STOP;
               end else begin
                  shift_d = shift_q >> 1;
                  bit_d   = bit_q + 1'b1;
               end
            end else if (bus.b_tick) begin
               tick_d = tick_q + 1'b1;
            end
         end
         STOP: begin
            if (tick_end) begin
               tick_d = '0;
               done_d = 1'b1;
               if (hold_valid_q) begin
                  shift_d      = hold_q;
                  hold_valid_d = 1'b0;
                  state_d      = START;
               end else if (accept) begin
                  // Same-cycle write goes straight to the shifter, bypassing the holding register.
                  shift_d      = bus.tx_data;
                  hold_d       = hold_q;
                  hold_valid_d = 1'b0;
                  state_d      = START;
               end else begin
                  state_d = IDLE;
               end
            end else if (bus.b_tick) begin
               tick_d = tick_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   assign bus.tx       = tx_q;
   assign bus.tx_done  = done_q;
   assign bus.tx_busy  = (state_q != IDLE);
   assign bus.tx_ready = !hold_valid_q;
   assign bus.state    = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: single frame, back-to-back with overrun, same-cycle
// write at stop end, reset mid-frame and stalled tick, with b_tick every 4 clk.
module tb_uart_tx;
   import uart_pkg::*;

   logic clk;
   logic rst;
   logic tick_en;
   logic [1:0] tick_ph;
   int n_checks;
   int n_fail;
   int start_len;

   uart_tx_if #(.DATA_BITS(8)) bus ();

   uart_tx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // b_tick is high for one posedge out of every four while enabled.
   always @(negedge clk) begin
      if (!tick_en) begin
         tick_ph    = 2'd0;
         bus.b_tick = 1'b0;
      end else begin
         bus.b_tick = (tick_ph == 2'd3);
         tick_ph    = tick_ph + 2'd1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic write_byte(input logic [7:0] b);
      bus.tx_start = 1'b1;
      bus.tx_data  = b;
      @(negedge clk);
      bus.tx_start = 1'b0;
   endtask

   task automatic wait_state(input uart_state_t s, input int budget, input string tag,
                             output int n);
      n = 0;
      while (bus.state != s && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({tag, " reach_state"}, 32'(n < budget), 32'd1);
   endtask

   // From DATA entry: bit i is sampled mid-bit at 32+64*i, stop at 544, done at 576.
   task automatic run_frame(input logic [7:0] exp_byte, input string tag, input bit late_en,
                            input logic [7:0] late_byte, output int start_n);
      int c;
      bit seen;
      wait_state(DATA, 1000, tag, start_n);
      c    = 0;
      seen = 1'b0;
      while (!seen && c < 700) begin
         @(negedge clk);
         c++;
         if (late_en && c == 576) bus.tx_start = 1'b0;
         if (c % 64 == 32 && c < 512) check({tag, " data_bit"}, 32'(bus.tx), 32'(exp_byte[c / 64]));
         if (c == 544) begin
            check({tag, " stop_tx"}, 32'(bus.tx), 32'd1);
            check({tag, " stop_state"}, 32'(bus.state), 32'(STOP));
         end
         if (late_en && c == 575) begin
            check({tag, " late_ready"}, 32'(bus.tx_ready), 32'd1);
            bus.tx_start = 1'b1;
            bus.tx_data  = late_byte;
         end
         if (bus.tx_done) seen = 1'b1;
      end
      bus.tx_start = 1'b0;
      check({tag, " done_cycle"}, 32'(c), 32'd576);
   endtask

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      rst          = 1'b1;
      tick_en      = 1'b0;
      bus.tx_start = 1'b0;
      bus.tx_data  = 8'h00;

      #1;
      check("reset tx", 32'(bus.tx), 32'd1);
      check("reset busy", 32'(bus.tx_busy), 32'd0);
      check("reset ready", 32'(bus.tx_ready), 32'd1);
      check("reset done", 32'(bus.tx_done), 32'd0);
      check("reset state", 32'(bus.state), 32'(IDLE));
      @(negedge clk);
      @(negedge clk);
      rst     = 1'b0;
      tick_en = 1'b1;
      @(negedge clk);

      // Single byte
      write_byte(8'h55);
      check("t1 start_tx", 32'(bus.tx), 32'd0);
      check("t1 start_state", 32'(bus.state), 32'(START));
      check("t1 start_busy", 32'(bus.tx_busy), 32'd1);
      check("t1 start_ready", 32'(bus.tx_ready), 32'd1);
      run_frame(8'h55, "t1", 1'b0, 8'h00, start_len);
      check("t1 end_busy", 32'(bus.tx_busy), 32'd0);
      check("t1 end_ready", 32'(bus.tx_ready), 32'd1);
      check("t1 end_state", 32'(bus.state), 32'(IDLE));
      @(negedge clk);
      check("t1 done_width", 32'(bus.tx_done), 32'd0);

      // Back-to-back with an overrun write
      write_byte(8'hA3);
      write_byte(8'h0F);
      check("t2 ready_after_hold", 32'(bus.tx_ready), 32'd0);
      write_byte(8'hFF);
      check("t2 ready_after_overrun", 32'(bus.tx_ready), 32'd0);
      run_frame(8'hA3, "t2a", 1'b0, 8'h00, start_len);
      check("t2 gap_state", 32'(bus.state), 32'(START));
      check("t2 gap_tx", 32'(bus.tx), 32'd0);
      check("t2 gap_ready", 32'(bus.tx_ready), 32'd1);
      run_frame(8'h0F, "t2b", 1'b0, 8'h00, start_len);
      check("t2 start_len", 32'(start_len), 32'd64);
      check("t2 end_state", 32'(bus.state), 32'(IDLE));
      check("t2 end_busy", 32'(bus.tx_busy), 32'd0);
      check("t2 end_tx", 32'(bus.tx), 32'd1);

      // Same-cycle write as the stop bit completes
      @(negedge clk);
      write_byte(8'h96);
      run_frame(8'h96, "t3a", 1'b1, 8'h81, start_len);
      check("t3 next_state", 32'(bus.state), 32'(START));
      check("t3 next_tx", 32'(bus.tx), 32'd0);
      check("t3 next_ready", 32'(bus.tx_ready), 32'd1);
      @(negedge clk);
      check("t3 done_once", 32'(bus.tx_done), 32'd0);
      run_frame(8'h81, "t3b", 1'b0, 8'h00, start_len);
      check("t3 start_len", 32'(start_len), 32'd63);
      check("t3 end_state", 32'(bus.state), 32'(IDLE));

      // Reset during data bit 3 of 0xC6
      @(negedge clk);
      write_byte(8'hC6);
      wait_state(DATA, 1000, "t4", start_len);
      repeat (200) @(negedge clk);
      check("t4 bit3_tx", 32'(bus.tx), 32'd0);
      #2 rst = 1'b1;
      #1;
      check("t4 rst_tx", 32'(bus.tx), 32'd1);
      check("t4 rst_busy", 32'(bus.tx_busy), 32'd0);
      check("t4 rst_ready", 32'(bus.tx_ready), 32'd1);
      check("t4 rst_state", 32'(bus.state), 32'(IDLE));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      write_byte(8'h3C);
      check("t4 restart_tx", 32'(bus.tx), 32'd0);
      run_frame(8'h3C, "t4", 1'b0, 8'h00, start_len);
      check("t4 end_state", 32'(bus.state), 32'(IDLE));

      // Stalled baud tick holds the start bit
      tick_en = 1'b0;
      @(negedge clk);
      write_byte(8'hE7);
      for (int i = 0; i < 10; i++) begin
         repeat (100) @(negedge clk);
         check("t5 stall_tx", 32'(bus.tx), 32'd0);
         check("t5 stall_state", 32'(bus.state), 32'(START));
      end
      tick_en = 1'b1;
      run_frame(8'hE7, "t5", 1'b0, 8'h00, start_len);
      check("t5 end_state", 32'(bus.state), 32'(IDLE));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-serial UART transmitter, 8N1, LSB first, driven by the shared 16x-oversampling baud tick `b_tick` from the baud generator. It is the transmit-side peer of the design's UART receiver and sits between the command/response logic and the FPGA TX pin. A one-entry holding register lets the producer queue the next byte while the current frame is on the line, so consecutive frames go out back-to-back with no idle gap.

## Interface
- `OVERSAMPLE`, 16: `b_tick` pulses per bit period; must be a power of two, at least 2.
- `DATA_BITS`, 8: data bits per frame.
- `clk` input 1: system clock.
- `rst` input 1: reset, asynchronous, active-high.
- `b_tick` input 1: one-`clk`-wide pulse at OVERSAMPLE × baud.
- `tx_start` input 1: write strobe; accepted only in a cycle where `tx_ready`=1.
- `tx_data` input DATA_BITS: byte sampled in the accepting cycle.
- `tx_ready` output 1: holding register empty; a write is possible.
- `tx_busy` output 1: a frame is on the line (state ≠ IDLE).
- `tx_done` output 1: one-`clk` pulse when a frame's stop bit completes.
- `tx` output 1: serial line, registered, idle high.

## Operation
- **States:** IDLE, START, DATA, STOP.
- **Counters:**
  - tick counter, log2(OVERSAMPLE) bits, increments only on `b_tick`;
  - bit counter, 0..DATA_BITS-1;
  - shift register, DATA_BITS wide, shifts right so `tx` = bit 0.
- **Write acceptance** (`tx_start && tx_ready`):
  - in IDLE with the holding register empty: load `tx_data` straight into the shift register and go to START next cycle;
  - otherwise: load `tx_data` into the holding register and set `hold_valid`.
- **IDLE:** `tx`=1, tick counter cleared. If `hold_valid`, move the holding register into the shift register, clear `hold_valid`, go to START.
- **START:** `tx`=0. On the OVERSAMPLE-th `b_tick` after entry (tick count = OVERSAMPLE-1 with `b_tick`): clear the tick counter and bit counter, go to DATA.
- **DATA:** `tx` = shift register bit 0. Each bit lasts OVERSAMPLE ticks. At the end of a bit:
  - if the bit counter = DATA_BITS-1, go to STOP;
  - otherwise shift right and increment the bit counter.
- **STOP:** `tx`=1 for OVERSAMPLE ticks. At the end, pulse `tx_done`, then choose the next frame in this priority:
  1. holding register, if valid: load it and go directly to START;
  2. a write accepted in the same cycle: load it and go directly to START;
  3. otherwise go to IDLE.
- `tx_data` is ignored when no write is accepted. A `tx_start` while `tx_ready`=0 is dropped silently, with no state change.

## Timing
- **Reset values:** state IDLE, `tx`=1, `tx_busy`=0, `tx_ready`=1, `tx_done`=0, counters 0, shift and holding registers 0, `hold_valid`=0.
- **Reset mid-frame:** the frame is abandoned, `tx` returns to 1 asynchronously, and queued data is lost.
- **Start latency:** a write accepted in IDLE in cycle N drives `tx`=0 at cycle N+1, since `tx` is registered.
- **Start-bit length:** the start bit lasts from entry until the OVERSAMPLE-th subsequent `b_tick`. The first start bit may therefore be short by up to one tick period; this is accepted.
- **Frame length:** (DATA_BITS+2) × OVERSAMPLE ticks, i.e. 160 ticks at the defaults.
- **`tx_ready`:** equals `!hold_valid`, combinational from the register.
  - It falls the cycle after a write into the holding register.
  - It rises the cycle after the holding register transfers into the shift register.
- **`tx_done`:** registered; high for exactly the cycle following the final stop tick. It pulses on back-to-back frames as well.
- **`tx_busy`:** high from the cycle `tx` first goes low until the cycle after the last stop tick, when no frame follows.
- **`b_tick` in the acceptance cycle:** ignored for counting.

## Structure
- Shared `uart_pkg`: state encoding localparams (IDLE=0, START=1, DATA=2, STOP=3) and defaults for OVERSAMPLE and DATA_BITS, common with the receiver.
- Single module. The holding register is inline; no sub-module is needed.
- Two-process style: one registered block, one next-state block.

## Test plan
- **Single byte:** after reset, write 0x55 with `b_tick` every 4 clk.
  - `tx` sequence: 0, 1,0,1,0,1,0,1,0, 1; each bit except the first start bit lasts 16 ticks (64 clk).
  - One `tx_done` pulse; then `tx_busy`=0 and `tx_ready`=1.
- **Back-to-back:** write 0xA3, then 0x0F mid-frame.
  - `tx_ready` drops to 0 after the second write.
  - After the stop bit of 0xA3, the start bit of 0x0F follows with zero idle cycles.
  - Two `tx_done` pulses, 160 ticks apart.
- **Overrun:** third write 0xFF while `tx_ready`=0.
  - 0xFF is dropped; only 0xA3 and 0x0F are transmitted.
- **Same-cycle write at stop end:** holding register empty, `tx_start` with 0x81 in the cycle STOP completes.
  - 0x81 starts immediately; `tx_done` still pulses once for the prior frame.
- **Reset mid-frame:** assert `rst` during data bit 3 of 0xC6.
  - `tx`=1, `tx_busy`=0, `tx_ready`=1 immediately.
  - A subsequent write of 0x3C transmits correctly.
- **No `b_tick`:** hold `b_tick` low for 1000 clk after a write.
  - `tx` stays 0 (start bit) and the state stays START.
